// File: rtl/i_mem_pipe.sv
// ---------------------------------------------------------------------------
// i_mem_pipe
//
// Loadable instruction memory for the front-end fetch path. The program is
// written at runtime through the loader port while the block is in LOAD mode.
// The final loader word (ld_last_i) switches the block to RUN mode. In RUN
// mode the memory is read-only and is accessed through a pipelined
// valid/ready fetch interface. Each fetch returns FETCH_WIDTH_P consecutive
// words, and the response arrives READ_LATENCY_P cycles after acceptance.
//
// Ports
//   clk_i         rising-edge clock
//   reset_n_i     asynchronous active-low reset
//   ld_start_i    return to LOAD mode; drops any in-flight fetches
//   ld_v_i        loader write strobe (honoured in LOAD mode only)
//   ld_addr_i     loader word address
//   ld_data_i     loader word data
//   ld_last_i     qualifies ld_v_i as the final word; the block then enters RUN
//   req_v_i       fetch request valid
//   req_ready_o   fetch request ready
//   req_addr_i    address of the first word of the fetch
//   resp_v_o      response valid
//   resp_ready_i  response ready
//   resp_addr_o   request address echoed with its response
//   resp_data_o   word k in bits [k*WORD_SIZE_P +: WORD_SIZE_P]; word k is
//                 taken from address req_addr_i + k, wrapped modulo DEPTH_P
//   mode_run_o    high while in RUN mode
// ---------------------------------------------------------------------------
module i_mem_pipe #(
  parameter  int WORD_SIZE_P    = 16,
  parameter  int DEPTH_P        = 256,
  parameter  int FETCH_WIDTH_P  = 1,
  parameter  int READ_LATENCY_P = 1,
  localparam int ADDR_WIDTH_LP  = $clog2(DEPTH_P)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   ld_start_i,
  input  logic                                   ld_v_i,
  input  logic [ADDR_WIDTH_LP-1:0]               ld_addr_i,
  input  logic [WORD_SIZE_P-1:0]                 ld_data_i,
  input  logic                                   ld_last_i,
  input  logic                                   req_v_i,
  output logic                                   req_ready_o,
  input  logic [ADDR_WIDTH_LP-1:0]               req_addr_i,
  output logic                                   resp_v_o,
  input  logic                                   resp_ready_i,
  output logic [ADDR_WIDTH_LP-1:0]               resp_addr_o,
  output logic [FETCH_WIDTH_P*WORD_SIZE_P-1:0]   resp_data_o,
  output logic                                   mode_run_o
);

  localparam int DATA_WIDTH_LP  = FETCH_WIDTH_P * WORD_SIZE_P;
  localparam int STAGE_WIDTH_LP = 1 + ADDR_WIDTH_LP + DATA_WIDTH_LP;
  localparam int PIPE_WIDTH_LP  = READ_LATENCY_P * STAGE_WIDTH_LP;

  typedef enum logic {
    LOAD_S = 1'b0,
    RUN_S  = 1'b1
  } state_e;

  // One pipeline stage. The read data is captured at acceptance, and the
  // later stages only carry it towards the output.
  typedef struct packed {
    logic                     v;
    logic [ADDR_WIDTH_LP-1:0] addr;
    logic [DATA_WIDTH_LP-1:0] data;
  } stage_t;

  state_e state_q, state_d;

  logic [WORD_SIZE_P-1:0] mem_q [DEPTH_P];

  stage_t [READ_LATENCY_P-1:0] pipe_q, pipe_d;
  stage_t                      stage_in;
  stage_t                      stage_out;

  logic [DATA_WIDTH_LP-1:0] rd_data;
  logic                     mem_we;
  logic                     stall;
  logic                     accept;
  logic                     flush;

  // Handshake qualifiers. A stalled response freezes the whole pipeline, so
  // no new request can be accepted while the output is blocked.
  assign stage_out   = pipe_q[READ_LATENCY_P-1];
  assign mode_run_o  = (state_q == RUN_S);
  assign stall       = stage_out.v & ~resp_ready_i;
  assign req_ready_o = mode_run_o & ~stall & ~ld_start_i;
  assign accept      = req_v_i & req_ready_o;
  assign flush       = mode_run_o & ld_start_i;
  assign mem_we      = (state_q == LOAD_S) & ld_v_i;

  assign resp_v_o    = stage_out.v;
  assign resp_addr_o = stage_out.addr;
  assign resp_data_o = stage_out.data;

  // Mode FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= LOAD_S;
    end else begin
      state_q <= state_d;
    end
  end

  // Mode FSM next state. In LOAD mode, ld_last_i takes priority, so an
  // ld_start_i in that same cycle has no effect.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_S: if (ld_v_i && ld_last_i) state_d = RUN_S;
      RUN_S:  if (ld_start_i)          state_d = LOAD_S;
      default: state_d = LOAD_S;
    endcase
  end

  // Storage array. It has no reset, so the loader must supply the contents.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  // Fetch read port. Word k comes from req_addr_i + k. The sum is truncated
  // to the address width, so a fetch near the top of memory wraps to zero.
  for (genvar k = 0; k < FETCH_WIDTH_P; k++) begin : g_rd
    logic [ADDR_WIDTH_LP-1:0] rd_addr;
    assign rd_addr = req_addr_i + ADDR_WIDTH_LP'(k);
    assign rd_data[k*WORD_SIZE_P +: WORD_SIZE_P] = mem_q[rd_addr];
  end

  // Stage 0 input. The valid bit marks an accepted request. The data is
  // sampled every cycle but matters only when valid is set.
  always_comb begin
    stage_in      = '0;
    stage_in.v    = accept;
    stage_in.addr = req_addr_i;
    stage_in.data = rd_data;
  end

  // Pipeline advance. Without a stall, every stage moves one step towards
  // the output. The concatenation drops the old output stage, and with a
  // single stage it reduces to loading stage_in. A stall holds every stage.
  // Leaving RUN discards all in-flight fetches. A response consumed in that
  // same cycle has already been delivered.
  always_comb begin
    pipe_d = pipe_q;
    if (flush) begin
      pipe_d = '0;
    end else if (!stall) begin
      pipe_d = PIPE_WIDTH_LP'({pipe_q, stage_in});
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

`ifndef SYNTHESIS
  // Record of which words have been loaded since reset. It is used only to
  // decide whether an unknown value in a response is a real error.
  logic [DEPTH_P-1:0] loaded_q;
  logic               resp_loaded;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      loaded_q <= '0;
    end else if (mem_we) begin
      loaded_q[ld_addr_i] <= 1'b1;
    end
  end

  // The memory is read-only in RUN mode, so the loaded record cannot change
  // while a response is in flight.
  always_comb begin
    resp_loaded = 1'b1;
    for (int k = 0; k < FETCH_WIDTH_P; k++) begin
      if (!loaded_q[resp_addr_o + ADDR_WIDTH_LP'(k)]) resp_loaded = 1'b0;
    end
  end

  a_resp_no_x : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (resp_v_o && resp_loaded) |-> !$isunknown(resp_data_o));

  a_resp_stable : assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (resp_v_o && !resp_ready_i && !ld_start_i) |=>
      (resp_v_o && $stable(resp_data_o) && $stable(resp_addr_o)));
`endif

endmodule

// File: tb/tb_i_mem_pipe.sv
// ---------------------------------------------------------------------------
// tb_i_mem_pipe
//
// Self-checking bench for i_mem_pipe. It instantiates one configuration:
// 4 words per fetch, 3 cycles of latency and 256 words of depth.
//
// A stimulus process drives the inputs just after each rising edge. A
// monitor samples on the falling edge. The monitor keeps a behavioural model
// made of three parts:
//   - a word array for the memory
//   - a mode flag
//   - a queue of accepted fetches, each with a count of pipeline advances
//     still needed before it reaches the output
// Each cycle, the monitor compares the DUT outputs against the model. It then
// applies the cycle's inputs to the model.
// ---------------------------------------------------------------------------
module tb_i_mem_pipe;

  localparam int W  = 16;
  localparam int D  = 256;
  localparam int F  = 4;
  localparam int L  = 3;
  localparam int AW = 8;
  localparam int DW = W * F;
  localparam int CW = 64;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          ldStart = 1'b0;
  logic          ldV = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [W-1:0]  ldData = '0;
  logic          ldLast = 1'b0;
  logic          reqV = 1'b0;
  logic          reqReady;
  logic [AW-1:0] reqAddr = '0;
  logic          respV;
  logic          respReady = 1'b0;
  logic [AW-1:0] respAddr;
  logic [DW-1:0] respData;
  logic          modeRun;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            rem;
  } exp_t;

  logic [W-1:0] mdlMem [D];
  logic         mdlRun = 1'b0;
  exp_t         mdlQ [$];

  i_mem_pipe #(
    .WORD_SIZE_P    (W),
    .DEPTH_P        (D),
    .FETCH_WIDTH_P  (F),
    .READ_LATENCY_P (L)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (resetN),
    .ld_start_i   (ldStart),
    .ld_v_i       (ldV),
    .ld_addr_i    (ldAddr),
    .ld_data_i    (ldData),
    .ld_last_i    (ldLast),
    .req_v_i      (reqV),
    .req_ready_o  (reqReady),
    .req_addr_i   (reqAddr),
    .resp_v_o     (respV),
    .resp_ready_i (respReady),
    .resp_addr_o  (respAddr),
    .resp_data_o  (respData),
    .mode_run_o   (modeRun)
  );

  // Free-running clock with a period of 10 time units.
  always #5 clk = ~clk;

  // Cycle counter, printed in failure messages.
  always @(posedge clk) cycle <= cycle + 1;

  // One comparison. It updates the counts and reports any difference.
  task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                             input logic [CW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s cycle %0d: got %h, expected %h", name, cycle, actual, expected);
    end
  endtask

  // Expected fetch result: consecutive words starting at address a, with the
  // address wrapping modulo the depth.
  function automatic logic [DW-1:0] mdlFetch(input int a);
    logic [DW-1:0] r;
    r = '0;
    for (int k = 0; k < F; k++) r[k*W +: W] = mdlMem[(a + k) % D];
    return r;
  endfunction

  // Monitor and scoreboard. It first checks the outputs against the model
  // and then applies the rising edge that ends this cycle.
  always @(negedge clk) begin
    logic expRespV, expStall, expReady;
    exp_t item;
    if (!resetN) begin
      checkOutput("rstRespV",  CW'(respV),    '0);
      checkOutput("rstReady",  CW'(reqReady), '0);
      checkOutput("rstMode",   CW'(modeRun),  '0);
      checkOutput("rstAddr",   CW'(respAddr), '0);
      checkOutput("rstData",   CW'(respData), '0);
      mdlQ.delete();
      mdlRun = 1'b0;
    end else begin
      expRespV = (mdlQ.size() > 0) && (mdlQ[0].rem == 0);
      expStall = expRespV && !respReady;
      expReady = mdlRun && !expStall && !ldStart;
      checkOutput("modeRun",  CW'(modeRun),  CW'(mdlRun));
      checkOutput("reqReady", CW'(reqReady), CW'(expReady));
      checkOutput("respV",    CW'(respV),    CW'(expRespV));
      if (expRespV) begin
        checkOutput("respAddr", CW'(respAddr), CW'(mdlQ[0].addr));
        checkOutput("respData", CW'(respData), CW'(mdlQ[0].data));
      end
      if (!mdlRun) begin
        if (ldV) begin
          mdlMem[ldAddr] = ldData;
          if (ldLast) mdlRun = 1'b1;
        end
      end else if (ldStart) begin
        mdlQ.delete();
        mdlRun = 1'b0;
      end else if (!expStall) begin
        if (expRespV) void'(mdlQ.pop_front());
        foreach (mdlQ[i]) if (mdlQ[i].rem > 0) mdlQ[i].rem = mdlQ[i].rem - 1;
        if (reqV && expReady) begin
          item.addr = reqAddr;
          item.data = mdlFetch(int'(reqAddr));
          item.rem  = L - 1;
          mdlQ.push_back(item);
        end
      end
    end
  end

  // Drives one cycle of inputs and then returns just after the next rising edge.
  task automatic applyStimulus(input logic s, input logic v, input logic [AW-1:0] a,
                               input logic [W-1:0] d, input logic last, input logic rv,
                               input logic [AW-1:0] ra, input logic rr);
    ldStart = s; ldV = v; ldAddr = a; ldData = d; ldLast = last;
    reqV = rv; reqAddr = ra; respReady = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit            inLoad;
    int            loadCnt;
    logic [AW-1:0] ra;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    // Fill the whole memory. Words 0..7 are 16'h1000+i, and ld_last_i is on word 7.
    for (int i = 8; i < D; i++) applyStimulus(0, 1, AW'(i), W'($urandom), 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, AW'(i), W'(16'h1000 + i), (i == 7), 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Back-to-back fetches with the consumer always ready.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0, 1, AW'(i), 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Two fetches, then the consumer stalls for several cycles.
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd4, 0);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd5, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 1, 8'd9, 0);
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Return to LOAD with two fetches in flight. Rewrite word 0, then fetch it.
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd10, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd11, 1);
    applyStimulus(1, 0, 0, 0, 0, 1, 8'd12, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'd0, 16'hBEEF, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd0, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // A fetch that wraps from the top of memory back to address 0.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'd254, 16'hAAAA, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'd255, 16'hBBBB, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'd0,   16'hCCCC, 0, 0, 0, 1);
    applyStimulus(0, 1, 8'd1,   16'hDDDD, 1, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 1, 8'd254, 1);
    repeat (5) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised traffic. It mixes stalls, reloads, and loader writes that
    // arrive in RUN mode and must be ignored. Some cycles assert ld_start_i
    // and ld_last_i together while in LOAD mode.
    inLoad = 0;
    loadCnt = 0;
    for (int n = 0; n < 1500; n++) begin
      ra = AW'($urandom);
      if (!inLoad) begin
        if ($urandom_range(0, 59) == 0) begin
          applyStimulus(1, 1'($urandom), AW'($urandom), W'($urandom), 1'($urandom),
                        1'($urandom), ra, 1'($urandom));
          inLoad = 1;
          loadCnt = 0;
        end else begin
          applyStimulus(0, 1'($urandom), AW'($urandom), W'($urandom), 1'($urandom),
                        ($urandom_range(0, 3) != 0), ra, ($urandom_range(0, 3) != 0));
        end
      end else begin
        loadCnt++;
        if (loadCnt > 3 && $urandom_range(0, 2) == 0) begin
          applyStimulus(1'($urandom), 1, AW'($urandom), W'($urandom), 1, 1'($urandom), ra, 1);
          inLoad = 0;
        end else begin
          applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom), AW'($urandom), W'($urandom),
                        0, 1'($urandom), ra, 1'($urandom));
        end
      end
    end
    if (inLoad) applyStimulus(0, 1, 8'd7, 16'h7777, 1, 0, 0, 1);

    // Asynchronous reset in the middle of a stream of fetches.
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 1, AW'($urandom), 1);
    #2 resetN = 1'b0;
    #1;
    checkOutput("asyncRstRespV", CW'(respV),    '0);
    checkOutput("asyncRstReady", CW'(reqReady), '0);
    checkOutput("asyncRstMode",  CW'(modeRun),  '0);
    @(posedge clk);
    @(posedge clk);
    #1 resetN = 1'b1;

    // Reload one word. The remaining contents survive the reset, and loader
    // writes in RUN mode must not change them.
    applyStimulus(0, 1, 8'd3, 16'h3333, 1, 0, 0, 1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(0, 1'($urandom), AW'($urandom), W'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) != 0), AW'($urandom), ($urandom_range(0, 3) != 0));
    end
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
